// File: rtl/pusch_dft_pkg.sv
// pusch_dft_pkg: shared FSM states, transform-size rules and twiddle table builder
package pusch_dft_pkg;
  localparam int MAX_N = 24;
  localparam int TW_W = 18;
  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;
  typedef logic signed [TW_W-1:0] tw_t;
  typedef tw_t [MAX_N-1:0] tw_tab_t;
  // twiddle step through the MAX_N-point table for size n; 0 marks an illegal size
  function automatic logic [4:0] step_of(logic [10:0] n);
    case (n)
      11'd1: return 5'd24;
      11'd2: return 5'd12;
      11'd3: return 5'd8;
      11'd4: return 5'd6;
      11'd6: return 5'd4;
      11'd8: return 5'd3;
      11'd12: return 5'd2;
      11'd24: return 5'd1;
      default: return 5'd0;
    endcase
  endfunction
  function automatic logic legal_n(logic [10:0] n);
    return step_of(n) != 5'd0;
  endfunction
  function automatic logic [4:0] mod_add(logic [4:0] a, logic [4:0] b);
    logic [5:0] t = {1'b0, a} + {1'b0, b};
    return (t >= 6'(MAX_N)) ? 5'(t - 6'(MAX_N)) : t[4:0];
  endfunction
  // first-quadrant cosine in 15-degree steps, 1.0 = 2^16 (TW_W = 18)
  function automatic int qc(int i);
    case (i)
      0: return 65536;
      1: return 63303;
      2: return 56756;
      3: return 46341;
      4: return 32768;
      5: return 16962;
      default: return 0;
    endcase
  endfunction
  function automatic int cos_q(int m);
    return m <= 6 ? qc(m) : m <= 12 ? -qc(12 - m) : m <= 18 ? -qc(m - 12) : qc(24 - m);
  endfunction
  // neg_sin=0 gives cos(2*pi*m/MAX_N), neg_sin=1 gives -sin(2*pi*m/MAX_N)
  function automatic tw_tab_t build_tw(bit neg_sin);
    tw_tab_t t;
    for (int m = 0; m < MAX_N; m++)
      t[m] = neg_sin ? tw_t'(-cos_q((m + 3 * MAX_N / 4) % MAX_N)) : tw_t'(cos_q(m));
    return t;
  endfunction
endpackage

// File: rtl/pusch_dft_if.sv
// pusch_dft_if: sample-in / bin-out bus of the PUSCH DFT core
interface pusch_dft_if #(parameter int WIDTH = 18);
  logic signed [WIDTH-1:0] di_re, di_im, do_re, do_im;
  logic Flag, done, do_en, Finish;
  logic [10:0] last_address, address;
  modport master (output di_re, di_im, Flag, done, last_address, input do_re, do_im, do_en, address, Finish);
  modport slave (input di_re, di_im, Flag, done, last_address, output do_re, do_im, do_en, address, Finish);
endinterface

// File: rtl/pusch_dft_twiddle_rom.sv
// pusch_dft_twiddle_rom: MAX_N-entry cos/-sin twiddle ROM with one-cycle registered read
module pusch_dft_twiddle_rom
  import pusch_dft_pkg::*;
(
  input  logic       clk,
  input  logic [4:0] addr,
  output tw_t        tw_re,
  output tw_t        tw_im
);
  localparam tw_tab_t COS_T = build_tw(1'b0);
  localparam tw_tab_t NSIN_T = build_tw(1'b1);
  // registered lookup so the twiddle lines up with the registered sample read
  always_ff @(posedge clk) begin
    tw_re <= COS_T[addr];
    tw_im <= NSIN_T[addr];
  end
endmodule

// File: rtl/pusch_dft_core.sv
// pusch_dft_core: sequential DFT (N | 24) with burst output; PUSCH_DFT_SAT_EN saturates bins instead of wrapping
module pusch_dft_core
  import pusch_dft_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int BURST = 8,
  parameter int GAP = 16
) (
  input logic        clk,
  input logic        reset,
  pusch_dft_if.slave s
);
  localparam int PROD_W = WIDTH + TW_W;
  localparam int ACC_W = WIDTH + TW_W + 5;
  localparam int BW = $clog2(BURST + 1);
  localparam int GW = $clog2(GAP + 1);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [ACC_W-1:0] MINV = -ACC_W'(2 ** (WIDTH - 1));
  state_t state;
  logic [4:0] n_len, last_i, step, cnt, k, kstep, idx, k1;
  logic [BW-1:0] bcnt;
  logic [GW-1:0] gcnt;
  logic issuing, v1, first1, last1;
  logic signed [WIDTH-1:0] in_re [MAX_N], in_im [MAX_N], out_re [MAX_N], out_im [MAX_N];
  logic signed [WIDTH-1:0] x_re, x_im, res_re, res_im;
  logic signed [ACC_W-1:0] acc_re, acc_im, nxt_re, nxt_im;
  tw_t w_re, w_im;
  assign last_i = n_len - 5'd1;
  function automatic logic signed [WIDTH-1:0] fit(logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh = a >>> (TW_W - 2);
`ifdef PUSCH_DFT_SAT_EN
    return (sh > MAXV) ? MAXV[WIDTH-1:0] : (sh < MINV) ? MINV[WIDTH-1:0] : sh[WIDTH-1:0];
`else
    return sh[WIDTH-1:0];
`endif
  endfunction
  pusch_dft_twiddle_rom u_rom (.clk(clk), .addr(idx), .tw_re(w_re), .tw_im(w_im));
  // complex MAC: 4 real products added into the running bin accumulator
  always_comb begin
    nxt_re = (first1 ? ACC_W'(0) : acc_re) + ACC_W'(PROD_W'(x_re) * PROD_W'(w_re)) - ACC_W'(PROD_W'(x_im) * PROD_W'(w_im));
    nxt_im = (first1 ? ACC_W'(0) : acc_im) + ACC_W'(PROD_W'(x_re) * PROD_W'(w_im)) + ACC_W'(PROD_W'(x_im) * PROD_W'(w_re));
    res_re = fit(nxt_re);
    res_im = fit(nxt_im);
  end
  // sample/bin buffers and the registered sample read feeding the MAC
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      in_re[cnt] <= s.di_re;
      in_im[cnt] <= s.di_im;
    end
    if (v1 && last1) begin
      out_re[k1] <= res_re;
      out_im[k1] <= res_im;
    end
    x_re <= in_re[cnt];
    x_im <= in_im[cnt];
  end
  // control FSM: arm, load, MAC issue with drain, burst sequencer with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      {n_len, step, cnt, k, kstep, idx, k1} <= '0;
      bcnt <= '0;
      gcnt <= '0;
      {issuing, v1, first1, last1} <= '0;
      acc_re <= '0;
      acc_im <= '0;
      s.do_re <= '0;
      s.do_im <= '0;
      s.address <= '0;
      s.do_en <= 1'b0;
      s.Finish <= 1'b0;
    end else begin
      s.do_en <= 1'b0;
      s.Finish <= 1'b0;
      v1 <= issuing;
      first1 <= cnt == 5'd0;
      last1 <= cnt == last_i;
      k1 <= k;
      if (v1) begin
        acc_re <= nxt_re;
        acc_im <= nxt_im;
      end
      case (state)
        IDLE: if (s.Flag && s.done && legal_n(s.last_address)) begin
          n_len <= s.last_address[4:0];
          step <= step_of(s.last_address);
          cnt <= '0;
          state <= LOAD;
        end
        LOAD: begin
          cnt <= (cnt == last_i) ? '0 : cnt + 5'd1;
          if (cnt == last_i) begin
            state <= CALC;
            issuing <= 1'b1;
            {k, kstep, idx} <= '0;
          end
        end
        CALC: if (issuing) begin
          if (cnt == last_i) begin
            cnt <= '0;
            idx <= '0;
            k <= k + 5'd1;
            kstep <= mod_add(kstep, step);
            issuing <= k != last_i;
          end else begin
            cnt <= cnt + 5'd1;
            idx <= mod_add(idx, kstep);
          end
        end else if (!v1) begin
          state <= OUT;
          cnt <= '0;
          bcnt <= '0;
          gcnt <= '0;
        end
        OUT: if (gcnt != '0) gcnt <= gcnt - GW'(1);
        else if (cnt == n_len) begin
          s.Finish <= 1'b1;
          state <= IDLE;
        end else begin
          s.do_en <= 1'b1;
          s.do_re <= out_re[cnt];
          s.do_im <= out_im[cnt];
          s.address <= 11'(cnt);
          cnt <= cnt + 5'd1;
          bcnt <= (bcnt == BW'(BURST - 1) || cnt == last_i) ? '0 : bcnt + BW'(1);
          if (bcnt == BW'(BURST - 1) && cnt != last_i) gcnt <= GW'(GAP);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pusch_dft_core.sv
// tb_pusch_dft_core: randomized and directed checks of pusch_dft_core against a floating-point-twiddle DFT model
module tb_pusch_dft_core;
  localparam real PI = 3.14159265358979323846;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  pusch_dft_if #(.WIDTH(18)) bus ();
  pusch_dft_core dut (.clk(clk), .reset(reset), .s(bus.slave));
  int n_tests = 0, n_fail = 0;
  int x_re [24], x_im [24];
  longint e_re [24], e_im [24], g_re [24], g_im [24];
  int legal [8] = '{1, 2, 3, 4, 6, 8, 12, 24};

  task automatic chk(string tag, longint got, longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint rnd(real r);
    return r >= 0.0 ? longint'($rtoi(r + 0.5)) : -longint'($rtoi(-r + 0.5));
  endfunction

  function automatic longint fit(longint v);
    longint t = v >>> 16;
`ifdef PUSCH_DFT_SAT_EN
    return t > 131071 ? 131071 : t < -131072 ? -131072 : t;
`else
    t = t & 64'h3FFFF;
    return t >= 131072 ? t - 262144 : t;
`endif
  endfunction

  task automatic model(int n);
    for (int k = 0; k < n; k++) begin
      longint ar = 0, ai = 0;
      for (int j = 0; j < n; j++) begin
        real a = 2.0 * PI * real'((j * k * (24 / n)) % 24) / 24.0;
        longint wr = rnd(65536.0 * $cos(a)), wi = rnd(-65536.0 * $sin(a));
        ar += x_re[j] * wr - x_im[j] * wi;
        ai += x_re[j] * wi + x_im[j] * wr;
      end
      e_re[k] = fit(ar);
      e_im[k] = fit(ai);
    end
  endtask

  task automatic run(int n, int abort_at);
    int j = 0, zeros = 0, fin = 0, en_cnt = 0, extra = 0;
    bit stop = 0, aborted = 0;
    model(n);
    @(negedge clk);
    bus.Flag = 1; bus.done = 1; bus.last_address = 11'(n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.Flag = 0; bus.done = 0;
      bus.di_re = 18'(x_re[i]); bus.di_im = 18'(x_im[i]);
    end
    for (int c = 0; c < 3000 && !stop; c++) begin
      @(negedge clk);
      if (bus.Finish) begin
        fin++;
        chk("bin_count", j, n);
        chk("finish_en", bus.do_en, 0);
        chk("finish_lat", zeros, 0);
        stop = 1;
      end else if (bus.do_en) begin
        en_cnt++;
        if (j > 0) chk("gap", zeros, (j % 8 == 0) ? 16 : 0);
        chk("addr", bus.address, j);
        if (j < 24) begin
          chk("bin_re", bus.do_re, e_re[j]);
          chk("bin_im", bus.do_im, e_im[j]);
          g_re[j] = bus.do_re; g_im[j] = bus.do_im;
        end
        j++; zeros = 0;
        if (j == abort_at) begin
          reset = 0;
          #1;
          chk("rst_en", bus.do_en, 0);
          chk("rst_re", bus.do_re, 0);
          chk("rst_im", bus.do_im, 0);
          chk("rst_addr", bus.address, 0);
          @(negedge clk);
          reset = 1;
          stop = 1; aborted = 1;
        end
      end else zeros++;
    end
    if (!aborted) begin
      chk("finish_seen", fin, 1);
      chk("en_cycles", en_cnt, n);
      repeat (40) begin
        @(negedge clk);
        if (bus.do_en || bus.Finish) extra++;
      end
      chk("quiet_after", extra, 0);
    end
  endtask

  initial begin
    int cnt = 0;
    longint d;
    bus.Flag = 0; bus.done = 0; bus.last_address = '0; bus.di_re = '0; bus.di_im = '0;
    repeat (3) @(negedge clk);
    chk("reset_en", bus.do_en, 0);
    chk("reset_fin", bus.Finish, 0);
    chk("reset_re", bus.do_re, 0);
    chk("reset_addr", bus.address, 0);
    reset = 1;
    for (int i = 0; i < 24; i++) begin x_re[i] = (i == 0) ? 1000 : 0; x_im[i] = 0; end
    run(24, -1);
    for (int i = 0; i < 24; i++) chk("impulse", g_re[i], 1000);
    for (int i = 0; i < 8; i++) begin x_re[i] = 100; x_im[i] = 0; end
    run(8, -1);
    chk("dc_bin0", g_re[0], 800);
    for (int i = 0; i < 12; i++) begin
      x_re[i] = int'(rnd(1000.0 * $cos(2.0 * PI * i / 12.0)));
      x_im[i] = int'(rnd(1000.0 * $sin(2.0 * PI * i / 12.0)));
    end
    run(12, -1);
    d = g_re[1] - 12000;
    chk("tone_bin1", (d <= 8 && d >= -8) ? 1 : 0, 1);
    @(negedge clk); bus.Flag = 1; bus.done = 1; bus.last_address = 11'd7;
    @(negedge clk); bus.done = 0; bus.last_address = 11'd8;
    @(negedge clk); bus.Flag = 0; bus.done = 1;
    @(negedge clk); bus.done = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.do_en || bus.Finish) cnt++;
    end
    chk("ignored_arm", cnt, 0);
    repeat (4) begin
      int n = legal[$urandom_range(0, 7)];
      for (int i = 0; i < 24; i++) begin
        x_re[i] = int'($urandom_range(0, 262143)) - 131072;
        x_im[i] = int'($urandom_range(0, 262143)) - 131072;
      end
      run(n, -1);
    end
    for (int i = 0; i < 8; i++) begin x_re[i] = 131071; x_im[i] = 0; end
    run(8, -1);
`ifdef PUSCH_DFT_SAT_EN
    chk("sat_bin0", g_re[0], 131071);
`else
    chk("wrap_bin0", g_re[0], -8);
`endif
    for (int i = 0; i < 24; i++) begin x_re[i] = 50 * i - 300; x_im[i] = 700 - 20 * i; end
    run(24, 10);
    for (int i = 0; i < 8; i++) begin
      x_re[i] = int'($urandom_range(0, 4095)) - 2048;
      x_im[i] = int'($urandom_range(0, 4095)) - 2048;
    end
    run(8, -1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
